// File: rtl/hazard_ctrl.sv
// hazard_ctrl: ID/EX hazard control (load-use and mult/div stalls, branch flush, saturating event counters)
//   clk_i, rst_i                : clock, synchronous active-high reset
//   ifid_rs_i/rt_i/use_rt_i     : source fields of the instruction in ID
//   ifid_hilo_i                 : ID instruction touches HI/LO
//   idex_mem_read_i, idex_rt_i  : EX load and its destination
//   idex_muldiv_i               : EX starts a mult/div
//   branch_taken_i              : EX resolved a taken branch/jump
//   clr_cnt_i                   : clear event counters
//   pc_write_o, ifid_write_o    : stall enables (active high = advance)
//   ifid_flush_o, idex_flush_o  : bubble inserts
//   muldiv_busy_o/done_o        : mult/div occupancy and final-cycle pulse
//   stall_cnt_o, flush_cnt_o    : saturating stall/flush cycle counts
module hazard_ctrl #(
  parameter int MULDIV_CYCLES = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       ifid_rs_i,
  input  logic [4:0]       ifid_rt_i,
  input  logic             ifid_use_rt_i,
  input  logic             ifid_hilo_i,
  input  logic             idex_mem_read_i,
  input  logic [4:0]       idex_rt_i,
  input  logic             idex_muldiv_i,
  input  logic             branch_taken_i,
  input  logic             clr_cnt_i,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             ifid_flush_o,
  output logic             idex_flush_o,
  output logic             muldiv_busy_o,
  output logic             muldiv_done_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);
  typedef enum logic {IDLE, BUSY} state_t;
  localparam logic [7:0] LOAD = 8'(MULDIV_CYCLES - 1);
  state_t state, state_n;
  logic [7:0] cnt, cnt_n;
  logic lu, md, stall;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      cnt <= '0;
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      stall_cnt_o <= clr_cnt_i ? '0 : stall_cnt_o + CNT_W'(~pc_write_o & ~&stall_cnt_o);
      flush_cnt_o <= clr_cnt_i ? '0 : flush_cnt_o + CNT_W'(branch_taken_i & ~&flush_cnt_o);
    end
  end
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    muldiv_busy_o = state == BUSY;
    muldiv_done_o = muldiv_busy_o & (cnt == 8'd0);
    if (state == IDLE && idex_muldiv_i) begin
      state_n = BUSY;
      cnt_n = LOAD;
    end else if (state == BUSY) begin
      state_n = muldiv_done_o ? IDLE : BUSY;
      cnt_n = muldiv_done_o ? cnt : cnt - 8'd1;
    end
    lu = idex_mem_read_i & (idex_rt_i != 5'd0) &
         ((idex_rt_i == ifid_rs_i) | (ifid_use_rt_i & (idex_rt_i == ifid_rt_i)));
    // HI/LO are written at the end of the cnt==0 cycle, so the consumer is released then
    md = muldiv_busy_o & (cnt != 8'd0) & ifid_hilo_i;
    stall = (lu | md) & ~branch_taken_i;
    pc_write_o = ~stall;
    ifid_write_o = ~stall;
    ifid_flush_o = branch_taken_i;
    idex_flush_o = branch_taken_i | stall;
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: randomized and directed self-checking bench for hazard_ctrl
module tb_hazard_ctrl;
  localparam int MD = 4;
  localparam int W = 4;
  localparam int SAT = 15;
  logic clk = 0, rst = 0;
  logic [4:0] rs, rt, ex_rt;
  logic use_rt, hilo, mem_read, muldiv, br, clr;
  logic pc_write, ifid_write, ifid_flush, idex_flush, busy, done;
  logic [W-1:0] stall_cnt, flush_cnt;
  int tests = 0, fails = 0;
  int rem = 0, scnt = 0, fcnt = 0;
  always #5 clk = ~clk;
  hazard_ctrl #(.MULDIV_CYCLES(MD), .CNT_W(W)) dut (
    .clk_i(clk), .rst_i(rst), .ifid_rs_i(rs), .ifid_rt_i(rt), .ifid_use_rt_i(use_rt),
    .ifid_hilo_i(hilo), .idex_mem_read_i(mem_read), .idex_rt_i(ex_rt),
    .idex_muldiv_i(muldiv), .branch_taken_i(br), .clr_cnt_i(clr),
    .pc_write_o(pc_write), .ifid_write_o(ifid_write), .ifid_flush_o(ifid_flush),
    .idex_flush_o(idex_flush), .muldiv_busy_o(busy), .muldiv_done_o(done),
    .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt));
  // rem = busy cycles still to come, including the current one
  function automatic bit model_stall();
    bit lu = mem_read && ex_rt != 0 && (ex_rt == rs || (use_rt && ex_rt == rt));
    bit md = rem > 1 && hilo;
    return (lu || md) && !br;
  endfunction
  function automatic logic [13:0] model_out();
    bit s = model_stall();
    return {!s, !s, br, br || s, rem > 0, rem == 1, 4'(scnt), 4'(fcnt)};
  endfunction
  task automatic tick();
    if (rst) begin
      rem = 0; scnt = 0; fcnt = 0;
    end else begin
      scnt = clr ? 0 : (model_stall() && scnt < SAT) ? scnt + 1 : scnt;
      fcnt = clr ? 0 : (br && fcnt < SAT) ? fcnt + 1 : fcnt;
      rem = rem > 0 ? rem - 1 : muldiv ? MD : 0;
    end
    @(posedge clk);
    #1;
  endtask
  task automatic clear_in();
    {rs, rt, ex_rt} = '0;
    {use_rt, hilo, mem_read, muldiv, br, clr, rst} = '0;
  endtask
  task automatic test_reset();
    clear_in();
    rst = 1;
    tick();
    tick();
    rst = 0;
    #2;
    tests++;
    if ({pc_write, ifid_write, ifid_flush, idex_flush, busy, done} !== 6'b110000) begin
      fails++; $display("FAIL reset_ctrl got=%b exp=110000", {pc_write, ifid_write, ifid_flush, idex_flush, busy, done});
    end
    tests++;
    if ({stall_cnt, flush_cnt} !== 8'h00) begin
      fails++; $display("FAIL reset_cnt got=%h exp=00", {stall_cnt, flush_cnt});
    end
  endtask
  task automatic test_load_use();
    mem_read = 1; ex_rt = 8; rs = 8;
    #2;
    tests++;
    if ({pc_write, ifid_write, ifid_flush, idex_flush} !== 4'b0001) begin
      fails++; $display("FAIL lu_stall got=%b exp=0001", {pc_write, ifid_write, ifid_flush, idex_flush});
    end
    tick();
    clear_in();
    #2;
    tests++;
    if (stall_cnt !== 4'd1) begin
      fails++; $display("FAIL lu_cnt got=%0d exp=1", stall_cnt);
    end
    mem_read = 1; ex_rt = 0; rs = 0;
    #2;
    tests++;
    if ({pc_write, idex_flush} !== 2'b10) begin
      fails++; $display("FAIL lu_r0 got=%b exp=10", {pc_write, idex_flush});
    end
    tick();
    ex_rt = 8; rs = 3; rt = 8; use_rt = 0;
    #2;
    tests++;
    if ({pc_write, idex_flush} !== 2'b10) begin
      fails++; $display("FAIL lu_no_use_rt got=%b exp=10", {pc_write, idex_flush});
    end
    use_rt = 1;
    #2;
    tests++;
    if ({pc_write, idex_flush} !== 2'b01) begin
      fails++; $display("FAIL lu_use_rt got=%b exp=01", {pc_write, idex_flush});
    end
    tick();
    clear_in();
    #2;
    tests++;
    if (stall_cnt !== 4'd2) begin
      fails++; $display("FAIL lu_cnt2 got=%0d exp=2", stall_cnt);
    end
  endtask
  task automatic test_muldiv();
    clr = 1;
    tick();
    clr = 0; muldiv = 1;
    #2;
    tests++;
    if ({pc_write, busy} !== 2'b10) begin
      fails++; $display("FAIL md_start got=%b exp=10", {pc_write, busy});
    end
    tick();
    muldiv = 0; hilo = 1;
    for (int i = 0; i < MD; i++) begin
      #2;
      tests++;
      if ({pc_write, ifid_write, ifid_flush, idex_flush, busy, done} !== (i < MD - 1 ? 6'b000110 : 6'b110011)) begin
        fails++; $display("FAIL md_cycle%0d got=%b", i, {pc_write, ifid_write, ifid_flush, idex_flush, busy, done});
      end
      tick();
    end
    #2;
    tests++;
    if ({pc_write, busy, done, stall_cnt} !== {3'b100, 4'd3}) begin
      fails++; $display("FAIL md_after got=%b cnt=%0d exp=100 cnt=3", {pc_write, busy, done}, stall_cnt);
    end
    clear_in();
  endtask
  task automatic test_branch_over_stall();
    clr = 1;
    tick();
    clr = 0; mem_read = 1; ex_rt = 5; rs = 5; br = 1;
    #2;
    tests++;
    if ({pc_write, ifid_write, ifid_flush, idex_flush} !== 4'b1111) begin
      fails++; $display("FAIL br_ctrl got=%b exp=1111", {pc_write, ifid_write, ifid_flush, idex_flush});
    end
    tick();
    clear_in();
    #2;
    tests++;
    if ({stall_cnt, flush_cnt} !== {4'd0, 4'd1}) begin
      fails++; $display("FAIL br_cnt got=%0d/%0d exp=0/1", stall_cnt, flush_cnt);
    end
  endtask
  task automatic test_saturation_clear();
    mem_read = 1; ex_rt = 9; rs = 9;
    for (int i = 0; i < 20; i++) tick();
    #2;
    tests++;
    if (stall_cnt !== 4'd15) begin
      fails++; $display("FAIL sat got=%0d exp=15", stall_cnt);
    end
    clr = 1;
    tick();
    clr = 0;
    #2;
    tests++;
    if (stall_cnt !== 4'd0) begin
      fails++; $display("FAIL clr got=%0d exp=0", stall_cnt);
    end
    clear_in();
  endtask
  task automatic test_reset_mid_op();
    muldiv = 1;
    tick();
    muldiv = 0;
    tick();
    rst = 1;
    #2;
    tests++;
    if (busy !== 1'b1) begin
      fails++; $display("FAIL rmid_busy got=%b exp=1", busy);
    end
    tick();
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      #2;
      tests++;
      if ({busy, done} !== 2'b00) begin
        fails++; $display("FAIL rmid_idle%0d got=%b exp=00", i, {busy, done});
      end
      tick();
    end
    muldiv = 1;
    tick();
    muldiv = 0;
    for (int i = 0; i < MD; i++) begin
      #2;
      tests++;
      if ({busy, done} !== (i < MD - 1 ? 2'b10 : 2'b11)) begin
        fails++; $display("FAIL rmid_restart%0d got=%b", i, {busy, done});
      end
      tick();
    end
  endtask
  task automatic test_random();
    for (int n = 0; n < 3000; n++) begin
      rst = $urandom_range(63) == 0;
      clr = $urandom_range(31) == 0;
      br = $urandom_range(7) == 0;
      muldiv = $urandom_range(5) == 0;
      mem_read = $urandom_range(1) == 1;
      hilo = $urandom_range(1) == 1;
      use_rt = $urandom_range(1) == 1;
      rs = 5'($urandom_range(3));
      rt = 5'($urandom_range(3));
      ex_rt = 5'($urandom_range(3));
      #2;
      tests++;
      if ({pc_write, ifid_write, ifid_flush, idex_flush, busy, done, stall_cnt, flush_cnt} !== model_out()) begin
        fails++; $display("FAIL random%0d got=%b exp=%b", n,
          {pc_write, ifid_write, ifid_flush, idex_flush, busy, done, stall_cnt, flush_cnt}, model_out());
      end
      tick();
    end
    clear_in();
  endtask
  initial begin
    clear_in();
    test_reset();
    test_load_use();
    test_muldiv();
    test_branch_over_stall();
    test_saturation_clear();
    test_reset_mid_op();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
